demux_4salidas_tdm: RTL and testbench



---
 rtl/demux_pkg.sv | 8 +
 rtl/demux_4salidas_tdm_slot_timer.sv | 29 ++
 rtl/demux_4salidas_tdm.sv | 52 +++++
 tb/tb_demux_4salidas_tdm.sv | 124 ++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// demux_pkg: shared slot type, slot count and divider counter width helper for the TDM demux
package demux_pkg;
  localparam int SLOT_COUNT = 4;
  typedef logic [1:0] slot_t;
  function automatic int cnt_w(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction
endpackage

// File: rtl/demux_4salidas_tdm_slot_timer.sv
// slot_timer: divides clk into DIV-cycle slots; ports clk/rst_n/en/resync in, slot index plus sample (last slot cycle) and last-slot strobes out
module slot_timer
  import demux_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  input  logic  resync,
  output slot_t slot,
  output logic  sample_stb,
  output logic  last_slot_stb
);
  localparam int CW = cnt_w(DIV);
  logic [CW-1:0] div_cnt;
  logic at_end;
  assign at_end = div_cnt == CW'(DIV - 1);
  assign sample_stb = en && !resync && at_end;
  assign last_slot_stb = sample_stb && slot == 2'd3;
  always_ff @(posedge clk)
    if (!rst_n || resync) begin
      div_cnt <= '0;
      slot <= '0;
    end else if (en) begin
      div_cnt <= at_end ? '0 : div_cnt + 1'b1;
      slot <= at_end ? slot + 1'b1 : slot;
    end
endmodule

// File: rtl/demux_4salidas_tdm.sv
// demux_4salidas_tdm: TDM receiver; drives sel1:sel0 to a remote 4:1 mux, samples ent once per slot, presents D0..D3 atomically per frame with a frame_valid pulse
module demux_4salidas_tdm
  import demux_pkg::*;
#(
  parameter int DIV = 4,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             resync,
  input  logic [WIDTH-1:0] ent,
  output logic             sel0,
  output logic             sel1,
  output logic [WIDTH-1:0] D0,
  output logic [WIDTH-1:0] D1,
  output logic [WIDTH-1:0] D2,
  output logic [WIDTH-1:0] D3,
  output logic             frame_valid
);
  slot_t slot;
  logic sample_stb, last_slot_stb;
  logic [WIDTH-1:0] shadow [SLOT_COUNT-1];
  slot_timer #(.DIV(DIV)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .resync(resync),
    .slot(slot),
    .sample_stb(sample_stb),
    .last_slot_stb(last_slot_stb)
  );
  assign {sel1, sel0} = slot;
  always_ff @(posedge clk)
    if (!rst_n) begin
      shadow <= '{default: '0};
      D0 <= '0;
      D1 <= '0;
      D2 <= '0;
      D3 <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= last_slot_stb;
      if (sample_stb && !last_slot_stb) shadow[slot] <= ent;
      if (last_slot_stb) begin
        D0 <= shadow[0];
        D1 <= shadow[1];
        D2 <= shadow[2];
        D3 <= ent;
      end
    end
endmodule

// File: tb/tb_demux_4salidas_tdm.sv
// tb_demux_4salidas_tdm: scoreboard bench for the TDM demux at DIV=4/WIDTH=1 and DIV=1/WIDTH=4
module tb_demux_4salidas_tdm;
  typedef struct {logic [15:0] d; int c;} exp_t;
  logic clk = 0;
  logic rst_n, en, resync, rst1_n;
  logic [3:0] src4;
  logic [15:0] src1 = 16'h0F5A;
  logic ent4;
  logic [3:0] ent1;
  logic s0a, s1a, fva, s0b, s1b, fvb;
  logic da0, da1, da2, da3;
  logic [3:0] db0, db1, db2, db3;
  int cyc = 0, base = 0, compared = 0, mism = 0;
  exp_t q4[$], q1[$];
  logic fva_prev = 0, fvb_prev = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign ent4 = src4[{s1a, s0a}];
  assign ent1 = src1[4*{s1b, s0b} +: 4];
  demux_4salidas_tdm #(.DIV(4), .WIDTH(1)) u4 (
    .clk(clk), .rst_n(rst_n), .en(en), .resync(resync), .ent(ent4),
    .sel0(s0a), .sel1(s1a), .D0(da0), .D1(da1), .D2(da2), .D3(da3), .frame_valid(fva)
  );
  demux_4salidas_tdm #(.DIV(1), .WIDTH(4)) u1 (
    .clk(clk), .rst_n(rst1_n), .en(1'b1), .resync(1'b0), .ent(ent1),
    .sel0(s0b), .sel1(s1b), .D0(db0), .D1(db1), .D2(db2), .D3(db3), .frame_valid(fvb)
  );
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mism++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, cyc - base, act, exp);
    end
  endtask
  task automatic to_edge(input int e);
    while (cyc - base < e) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push4(input logic [3:0] v, input int e);
    q4.push_back('{16'(v), base + e});
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (fva) begin
      chk("fv4_single", 16'(fva_prev), 16'h0);
      if (q4.size() == 0) chk("fv4_unexpected", 16'h1, 16'h0);
      else begin
        e = q4.pop_front();
        chk("d4_data", 16'({da3, da2, da1, da0}), e.d);
        chk("d4_edge", 16'(cyc - base), 16'(e.c - base));
      end
    end
    if (fvb) begin
      chk("fv1_single", 16'(fvb_prev), 16'h0);
      if (q1.size() == 0) chk("fv1_unexpected", 16'h1, 16'h0);
      else begin
        e = q1.pop_front();
        chk("d1_data", {db3, db2, db1, db0}, e.d);
        chk("d1_edge", 16'(cyc - base), 16'(e.c - base));
      end
    end
    fva_prev = fva;
    fvb_prev = fvb;
  end
  initial begin
    rst_n = 0; rst1_n = 0; en = 1; resync = 0; src4 = 4'b0001;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1; rst1_n = 1; base = cyc;
    chk("rst_d", 16'({da3, da2, da1, da0}), 16'h0);
    chk("rst_fv", 16'(fva), 16'h0);
    for (int k = 1; k <= 8; k++) q1.push_back('{16'h0F5A, base + 4 * k});
    push4(src4, 16);
    for (int k = 1; k <= 16; k++) begin
      to_edge(k);
      chk("sel_seq", 16'({s1a, s0a}), 16'((k / 4) % 4));
    end
    src4 = 4'b0010; push4(src4, 32);
    to_edge(32);
    rst1_n = 0;
    src4 = 4'b0100; push4(src4, 48);
    to_edge(48);
    src4 = 4'b1000; push4(src4, 64);
    to_edge(64);
    src4 = 4'b1010; push4(src4, 80);
    to_edge(80);
    src4 = 4'b0110; push4(src4, 105);
    to_edge(88);
    chk("pre_resync_sel", 16'({s1a, s0a}), 16'h2);
    resync = 1;
    to_edge(89);
    resync = 0;
    chk("resync_sel", 16'({s1a, s0a}), 16'h0);
    chk("resync_d_hold", 16'({da3, da2, da1, da0}), 16'b1010);
    chk("resync_fv", 16'(fva), 16'h0);
    to_edge(105);
    src4 = 4'b0101; push4(src4, 126);
    to_edge(110);
    en = 0;
    for (int k = 111; k <= 115; k++) begin
      to_edge(k);
      chk("stall_sel", 16'({s1a, s0a}), 16'h1);
    end
    en = 1;
    to_edge(126);
    src4 = 4'b1111; push4(src4, 142);
    to_edge(151);
    chk("pre_rst_d", 16'({da3, da2, da1, da0}), 16'hF);
    rst_n = 0;
    to_edge(152);
    rst_n = 1;
    chk("mid_rst_d", 16'({da3, da2, da1, da0}), 16'h0);
    chk("mid_rst_sel", 16'({s1a, s0a}), 16'h0);
    chk("mid_rst_fv", 16'(fva), 16'h0);
    src4 = 4'b0011; push4(src4, 168);
    to_edge(172);
    chk("q4_drained", 16'(q4.size()), 16'h0);
    chk("q1_drained", 16'(q1.size()), 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
